// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles framed bytes into 16-bit words, writes them to program memory, and holds the core in reset until a complete image is loaded.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CSUM_EN.
module prog_loader #(
    parameter int          ADDR_WIDTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  pm_we,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic [15:0]           pm_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef PROG_LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, COUNT, LO, HI, WRITE, DONE, ERROR, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, COUNT, LO, HI, WRITE, DONE, ERROR} state_t;
`endif

    state_t              state;
    state_t              state_next;
    logic [ADDR_WIDTH:0] n_words;
    logic                take;
    logic                is_sync;
    logic                count_ok;
    logic                last_word;

    assign take      = rx_valid && rx_ready;
    assign is_sync   = (rx_data == SYNC_BYTE);
    assign count_ok  = (rx_data != 8'h00) && (int'(rx_data) <= DEPTH);
    assign last_word = ((words_loaded + (ADDR_WIDTH+1)'(1)) == n_words);

`ifdef PROG_LOADER_CSUM_EN
    logic [7:0] sum;
    logic       sum_ok;
    assign sum_ok = ((sum + rx_data) == 8'h00);
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take && is_sync) state_next = COUNT;
            COUNT:   if (take) state_next = count_ok ? LO : ERROR;
            LO:      if (take) state_next = HI;
            HI:      if (take) state_next = WRITE;
`ifdef PROG_LOADER_CSUM_EN
            WRITE:   state_next = last_word ? CSUM : LO;
            CSUM:    if (take) state_next = sum_ok ? DONE : ERROR;
`else
            WRITE:   state_next = last_word ? DONE : LO;
`endif
            DONE:    if (take && is_sync) state_next = COUNT;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            core_hold    <= 1'b1;
            rx_ready     <= 1'b1;
            pm_we        <= 1'b0;
            pm_addr      <= '0;
            pm_wdata     <= '0;
            busy         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            n_words      <= '0;
`ifdef PROG_LOADER_CSUM_EN
            sum          <= '0;
`endif
        end else begin
            state    <= state_next;
            rx_ready <= (state_next != WRITE) && (state_next != ERROR);
            busy     <= (state_next != IDLE) && (state_next != DONE);
            pm_we    <= (state_next == WRITE);
            case (state)
                IDLE, DONE: begin
                    if (take && is_sync) begin
                        error        <= 1'b0;
                        words_loaded <= '0;
                        core_hold    <= 1'b1;
                    end else if (state == DONE) begin
                        core_hold <= 1'b0;
                    end
                end
                COUNT: begin
                    if (take) begin
                        if (count_ok) begin
                            n_words <= (ADDR_WIDTH+1)'(rx_data);
                            pm_addr <= '0;
`ifdef PROG_LOADER_CSUM_EN
                            sum     <= rx_data;
`endif
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LO: begin
                    if (take) begin
                        pm_wdata[7:0] <= rx_data;
`ifdef PROG_LOADER_CSUM_EN
                        sum           <= sum + rx_data;
`endif
                    end
                end
                HI: begin
                    if (take) begin
                        pm_wdata[15:8] <= rx_data;
`ifdef PROG_LOADER_CSUM_EN
                        sum            <= sum + rx_data;
`endif
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
                    pm_addr      <= pm_addr + ADDR_WIDTH'(1);
                end
`ifdef PROG_LOADER_CSUM_EN
                CSUM: begin
                    if (take && !sum_ok) error <= 1'b1;
                end
`endif
                default: core_hold <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames checked against a frame-level reference model.
module tb_prog_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [15:0]   pm_wdata;
    logic          core_hold;
    logic          busy;
    logic          error;
    logic [AW:0]   words_loaded;

    int n_checks = 0;
    int n_fails  = 0;

    int          addr_q[$];
    int          data_q[$];
    int          low_cycles = 0;
    int          low_run2   = 0;
    int          double_we  = 0;
    logic        prev_we    = 1'b0;
    logic        prev_low   = 1'b0;
    logic [15:0] fw[DEPTH];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .core_hold(core_hold), .busy(busy), .error(error), .words_loaded(words_loaded)
    );

    // Observe the write port and the ready line between active edges.
    always @(negedge clk) begin
        if (!reset) begin
            if (pm_we) begin
                addr_q.push_back(int'(pm_addr));
                data_q.push_back(int'(pm_wdata));
                if (prev_we) double_we++;
            end
            if (!rx_ready) begin
                low_cycles++;
                if (prev_low) low_run2++;
            end
        end
        prev_we  = pm_we;
        prev_low = !rx_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int gapmax);
        if (gapmax > 0) idle($urandom_range(0, gapmax));
    endtask

    // Offers one byte from a negedge and returns at the negedge after it was taken.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        bit taken;
        waited = 0;
        taken  = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!taken) begin
            taken = rx_ready;
            @(posedge clk);
            @(negedge clk);
            if (!taken) begin
                waited++;
                if (waited > 64) begin
                    check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
                    taken = 1'b1;
                end
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic clear_writes();
        addr_q.delete();
        data_q.delete();
    endtask

    task automatic expect_writes(input string tag, input int nw);
        check({tag, "_nwrites"}, addr_q.size(), nw);
        for (int i = 0; i < nw && i < addr_q.size(); i++) begin
            check({tag, "_addr"}, addr_q[i], i);
            check({tag, "_data"}, data_q[i], {16'd0, fw[i]});
        end
    endtask

    task automatic expect_status(input string tag, input bit exp_err, input int exp_words);
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_core_hold"}, {31'd0, core_hold}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_words_loaded"}, {27'd0, words_loaded}, exp_words);
    endtask

    // Reference model: a frame with 1..DEPTH words loads them all at addresses 0..N-1 and releases the core; anything else is a frame error.
    task automatic run_frame(input string tag, input int n, input int gapmax, input int ngarb);
        bit         ok;
        logic [7:0] s;
        logic [7:0] g;
        ok = (n >= 1) && (n <= DEPTH);
        clear_writes();
        for (int i = 0; i < ngarb; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g);
            gap(gapmax);
        end
        send_byte(8'hA5);
        gap(gapmax);
        send_byte(n[7:0]);
        s = n[7:0];
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                gap(gapmax);
                send_byte(fw[i][7:0]);
                gap(gapmax);
                send_byte(fw[i][15:8]);
                s = s + fw[i][7:0] + fw[i][15:8];
            end
`ifdef PROG_LOADER_CSUM_EN
            gap(gapmax);
            send_byte(8'(8'd0 - s));
`endif
        end
        idle(4);
        expect_writes(tag, ok ? n : 0);
        expect_status(tag, !ok, ok ? n : 0);
    endtask

    initial begin
        int low0;
        int n;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_core_hold", {31'd0, core_hold}, 32'd1);
        check("rst_pm_we", {31'd0, pm_we}, 32'd0);
        check("rst_pm_addr", {28'd0, pm_addr}, 32'd0);
        check("rst_pm_wdata", {16'd0, pm_wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_words", {27'd0, words_loaded}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word frame with continuous valid and exact release latency.
        clear_writes();
        fw[0] = 16'h2C0C;
        fw[1] = 16'h2401;
        send_byte(8'hA5);
        check("f1_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h02);
        send_byte(8'h0C);
        send_byte(8'h2C);
        send_byte(8'h01);
        send_byte(8'h24);
`ifdef PROG_LOADER_CSUM_EN
        send_byte(8'hA1);
`else
        check("f1_we_k1", {31'd0, pm_we}, 32'd1);
        check("f1_hold_k1", {31'd0, core_hold}, 32'd1);
        @(negedge clk);
        check("f1_we_k2", {31'd0, pm_we}, 32'd0);
        check("f1_hold_k2", {31'd0, core_hold}, 32'd1);
        @(negedge clk);
        check("f1_hold_k3", {31'd0, core_hold}, 32'd0);
`endif
        idle(3);
        expect_writes("f1", 2);
        expect_status("f1", 1'b0, 2);

        // Garbage before sync is ignored.
        clear_writes();
        fw[0] = 16'h1234;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        check("garb_hold_kept", {31'd0, core_hold}, 32'd0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h34);
        send_byte(8'h12);
`ifdef PROG_LOADER_CSUM_EN
        send_byte(8'hB9);
`endif
        idle(4);
        expect_writes("garb", 1);
        expect_status("garb", 1'b0, 1);

        // Illegal word counts, error stickiness, and clearing on the next sync.
        run_frame("n0", 0, 0, 0);
        run_frame("n17", 17, 0, 0);
        send_byte(8'h13);
        idle(2);
        check("err_sticky", {31'd0, error}, 32'd1);
        clear_writes();
        fw[0] = 16'h1234;
        send_byte(8'hA5);
        check("err_cleared", {31'd0, error}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h34);
        send_byte(8'h12);
`ifdef PROG_LOADER_CSUM_EN
        send_byte(8'hB9);
`endif
        idle(4);
        expect_writes("after_err", 1);
        expect_status("after_err", 1'b0, 1);

        // Full-depth frame with valid held high: one ready drop per word.
        for (int i = 0; i < DEPTH; i++) fw[i] = 16'($urandom());
        fw[3] = 16'hA5A5;
        low0 = low_cycles;
        run_frame("full", DEPTH, 0, 0);
        check("full_ready_drops", low_cycles - low0, DEPTH);

        // Reload from DONE reasserts core_hold right after the sync byte.
        clear_writes();
        fw[0] = 16'h55AA;
        send_byte(8'hA5);
        check("reload_hold", {31'd0, core_hold}, 32'd1);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'h55);
`ifdef PROG_LOADER_CSUM_EN
        send_byte(8'h00);
`endif
        idle(4);
        expect_writes("reload", 1);
        expect_status("reload", 1'b0, 1);

        // Reset in the middle of a frame.
        clear_writes();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h0C);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_nwrites", addr_q.size(), 0);
        check("midrst_hold", {31'd0, core_hold}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, rx_ready}, 32'd1);
        check("midrst_words", {27'd0, words_loaded}, 32'd0);
        fw[0] = 16'h9400;
        run_frame("postrst", 1, 0, 0);

`ifdef PROG_LOADER_CSUM_EN
        // Checksum accept and reject.
        clear_writes();
        fw[0] = 16'h1234;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34); send_byte(8'h12); send_byte(8'hB9);
        idle(4);
        expect_writes("csum_ok", 1);
        expect_status("csum_ok", 1'b0, 1);
        clear_writes();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34); send_byte(8'h12); send_byte(8'hB8);
        idle(4);
        expect_writes("csum_bad", 1);
        expect_status("csum_bad", 1'b1, 1);
`endif

        // Randomized frames with idle gaps, leading garbage, and some illegal counts.
        for (int it = 0; it < 10; it++) begin
            if (it % 4 == 3)
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(DEPTH + 1, 255));
            else
                n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < DEPTH; i++) fw[i] = 16'($urandom());
            run_frame("rand", n, 3, int'($urandom_range(0, 2)));
        end

        check("we_single_cycle", double_we, 0);
        check("ready_single_drop", low_run2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader: the writer side of the core's program memory. The core only reads program memory via pc; this block fills it.
- Receives a framed byte stream (from a UART receiver or testbench) and assembles 16-bit instruction words.
- Writes the words sequentially into the program memory write port.
- Holds the AVR core in reset until a complete, valid image is loaded.

Parameters:
- ADDR_WIDTH, 4, program memory address width; depth = 2^ADDR_WIDTH words (matches the 4-bit pc).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at a rising edge.
- pm_we  output  1  program memory write strobe, one-cycle pulse.
- pm_addr  output  ADDR_WIDTH  program memory write address.
- pm_wdata  output  16  program memory write data.
- core_hold  output  1  drives the core's reset; high = core held.
- busy  output  1  frame in progress (any state other than IDLE or DONE).
- error  output  1  sticky frame error flag.
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current/last frame.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (reset). All state is updated on the rising clk edge only.
- Reset values:
  - state = IDLE
  - core_hold = 1
  - rx_ready = 1
  - pm_we = 0
  - pm_addr = 0
  - pm_wdata = 0
  - busy = 0
  - error = 0
  - words_loaded = 0
- Frame format: SYNC_BYTE, N (word count), then N words, each sent low byte first then high byte.
- States:
  - IDLE: waits for a byte. A byte equal to SYNC_BYTE → COUNT; clear error, clear words_loaded, set core_hold = 1. Any other byte is discarded.
  - COUNT: accept N.
    - N == 0 or N > 2^ADDR_WIDTH → ERROR.
    - Otherwise latch N, set pm_addr = 0, go to LO.
  - LO: accept byte into pm_wdata[7:0] → HI.
  - HI: accept byte into pm_wdata[15:8] → WRITE.
  - WRITE: exactly one cycle.
    - pm_we = 1 with stable pm_addr and pm_wdata; rx_ready = 0.
    - Increment words_loaded.
    - If words_loaded+1 == N → DONE (or CSUM when the option is enabled); otherwise → LO.
    - pm_addr increments on exit from WRITE. It wraps to 0 only when N == 2^ADDR_WIDTH, after the final write, and is not used again in that frame.
  - DONE: core_hold = 0 from the cycle after entry. Stays here.
    - A received SYNC_BYTE re-enters COUNT and reasserts core_hold on the next edge.
    - Other bytes are discarded.
  - ERROR: error = 1, core_hold = 1, then → IDLE next cycle. error stays 1 until the next SYNC_BYTE.
- rx_ready = 1 in every state except WRITE and ERROR.
- rx_valid while rx_ready = 0: the byte is not consumed; the source must hold it (valid/ready rule).
- Byte values equal to SYNC_BYTE inside a frame (COUNT/LO/HI) are data, not resync.
- reset mid-frame: returns to IDLE with the reset values above. Partially written memory is not cleared; core_hold = 1.
- pm_we never asserts outside WRITE.
- Latency: last high byte accepted at edge k → pm_we high during cycle k+1 → core_hold low from edge k+2 (option disabled).

Optional Feature:
- Macro: PROG_LOADER_CSUM_EN.
- Enabled:
  - After the last WRITE go to CSUM and accept one byte C.
  - Valid when (N + all data bytes + C) mod 256 == 0 → DONE.
  - Otherwise → ERROR; core_hold stays 1. Words already written remain in memory.
  - Running 8-bit sum register is cleared on SYNC_BYTE.
- Disabled:
  - No CSUM state and no sum register.
  - WRITE of the last word goes directly to DONE.

Test Plan:
- Reset, then A5, 02, 0C 2C, 01 24 with continuous valid:
  - pm_we pulses twice: addr 0 data 16'h2C0C, then addr 1 data 16'h2401.
  - words_loaded = 2; core_hold falls 2 cycles after the last byte; error = 0.
- Garbage 00 FF 13 then A5 01 34 12 → bytes before sync ignored; single write addr 0 data 16'h1234; core_hold = 0.
- A5 00 and, separately, A5 11 (17 > 16) → error = 1, no pm_we, core_hold = 1; state returns to IDLE.
- A5 10 followed by 16 words, rx_valid held high throughout:
  - rx_ready drops for exactly 16 single cycles, with no byte lost.
  - Writes land at addr 0..15; words_loaded = 16.
- After DONE, send A5 01 AA 55 → core_hold reasserts, then releases again; addr 0 data 16'h55AA.
- Reset asserted after A5 02 0C → no pm_we, core_hold = 1, busy = 0. Then a new frame A5 01 00 94 loads 16'h9400 at addr 0.
- With PROG_LOADER_CSUM_EN:
  - A5 01 34 12 B9 → DONE (01+34+12+B9 = 0x100).
  - Same frame with B8 → error = 1, core_hold = 1.
